frame_interpolator_weighted: RTL and testbench
==============================================

Name: frame_interpolator_weighted

Overview:
- Streaming, pipelined successor to the combinational averaging interpolator. Blends co-located pixels of the last and current frame scanlines with a programmable weight to synthesize intermediate frames (e.g. 1/4, 1/2, 3/4 phases for frame-rate upconversion).
- Sits between the frame buffer readout and the upscaler output path.
- Uses a valid/ready handshake with full backpressure. Tracks line position and tags start-of-frame and end-of-line beats.

Parameters:
- PIXELS_PER_BEAT, 4: pixels processed in parallel per beat.
- CHANNELS, 3: colour channels per pixel (RGB).
- CHANNEL_WIDTH, 8: bits per channel.
- WEIGHT_WIDTH, 4: fractional weight bits W; blend resolution is 1/2^W.
- BEATS_PER_LINE, 320: beats per scanline (1280 px / 4).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous active-high reset.
- cfg_weight, input, WEIGHT_WIDTH+1: weight w of the current frame, range 0..2^W; values above 2^W saturate to 2^W.
- cfg_mode, input, 2: 0 = weighted blend, 1 = pass last, 2 = pass current, 3 = fixed average (w = 2^(W-1)).
- in_valid, input, 1: input beat valid.
- in_ready, output, 1: block can accept a beat.
- in_sof, input, 1: first beat of a frame.
- in_last, input, PIXELS_PER_BEAT*CHANNELS*CHANNEL_WIDTH: beat from the last frame.
- in_cur, input, PIXELS_PER_BEAT*CHANNELS*CHANNEL_WIDTH: co-located beat from the current frame.
- out_valid, output, 1: output beat valid.
- out_ready, input, 1: downstream accepts the beat.
- out_sof, output, 1: sof tag aligned with out_data.
- out_eol, output, 1: asserted on beat BEATS_PER_LINE-1 of each line.
- out_data, output, PIXELS_PER_BEAT*CHANNELS*CHANNEL_WIDTH: interpolated beat.
- err_sof_misalign, output, 1: sticky; sof arrived when the beat counter was nonzero.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - out_valid=0, out_sof=0, out_eol=0, out_data=0, err_sof_misalign=0.
  - Beat counter=0; latched weight=2^(W-1); latched mode=3.
  - Both pipeline stages emptied.
  - in_ready=0 during the reset cycle, and 1 from the first cycle after reset.
- Input transfer: occurs when in_valid && in_ready. Output transfer: occurs when out_valid && out_ready.
- Configuration latch:
  - cfg_weight and cfg_mode are latched only on a transfer with in_sof=1.
  - The latched values apply to that beat and every following beat until the next sof; mid-frame cfg changes are ignored.
  - Effective weight we: mode 0 = sat(cfg_weight); mode 1 = 0; mode 2 = 2^W; mode 3 = 2^(W-1).
- Arithmetic, per channel, unsigned:
  - p = last*(2^W - we) + cur*we + 2^(W-1); result = p >> W.
  - Intermediate width is CHANNEL_WIDTH+W+1; no truncation before the shift.
  - we=0 returns last exactly; we=2^W returns cur exactly.
  - Rounding is half-up.
- Pipeline:
  - Stage 1 registers the two products per channel plus tags. Stage 2 registers the sum, shift and tags.
  - Latency is 2 cycles from input transfer to out_valid with no stall.
  - Throughput is 1 beat/cycle.
- Backpressure:
  - A stage advances when it is empty or the stage after it advances.
  - in_ready = !s1_valid || s1_advance (combinational from out_ready through both stages).
  - No beats are dropped or duplicated. out_data, out_sof and out_eol hold stable while out_valid && !out_ready.
- Beat counter:
  - Increments on each input transfer and wraps from BEATS_PER_LINE-1 to 0.
  - The eol tag is computed at input and carried through the pipeline.
- sof handling:
  - A transfer with in_sof=1 forces the counter to 0 for that beat, so that beat counts as beat 0.
  - If the counter was nonzero at that moment, err_sof_misalign sets. It stays set until rst.
- Simultaneous events: an input transfer and an output transfer in the same cycle are both honoured, and the pipeline stays full.
- Reset mid-operation: rst has priority over every handshake; in-flight beats are discarded and the sticky error clears.

Test Plan:
- Latch and blend: W=4, mode 0, cfg_weight=4, sof beat with last=0x40, cur=0xC0 on all channels, out_ready=1 -> after 2 cycles out_data channels = 0x60, out_sof=1.
- Mode and saturation checks: cfg_weight=31 in mode 0 -> output equals cur. Mode 1 -> equals last. Mode 3 with last=0x01, cur=0x02 -> 0x02 (half-up rounding). last=0xFF, cur=0xFF, w=8 -> 0xFF (no overflow).
- Mid-frame config change: change cfg_weight from 4 to 12 on beat 5 with no sof -> all beats keep weight 4 until the next sof beat, which uses 12.
- Backpressure: stream 10 beats with random out_ready (30% low) -> 10 beats emerge in order, unchanged while stalled, and in_ready drops only when both stages are full and stalled.
- Line counting and misalignment: 2*BEATS_PER_LINE continuous beats -> out_eol on beats 319 and 639. An in_sof at counter value 7 -> err_sof_misalign=1 and that beat is treated as beat 0.
- Reset mid-stream: assert rst for 1 cycle with 2 beats in flight -> next cycle out_valid=0 and err cleared, then in_ready=1, and the following sof beat emerges with latency 2.

Source files
------------

// File: rtl/frame_interpolator_weighted.sv
// Two-stage weighted blend of co-located last/current frame beats with valid/ready
// backpressure, per-line beat counting and start-of-frame alignment checking.
module frame_interpolator_weighted #(
    parameter int PIXELS_PER_BEAT = 4,
    parameter int CHANNELS        = 3,
    parameter int CHANNEL_WIDTH   = 8,
    parameter int WEIGHT_WIDTH    = 4,
    parameter int BEATS_PER_LINE  = 320
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [WEIGHT_WIDTH:0]                             cfg_weight,
    input  logic [1:0]                                        cfg_mode,
    input  logic                                              in_valid,
    output logic                                              in_ready,
    input  logic                                              in_sof,
    input  logic [PIXELS_PER_BEAT*CHANNELS*CHANNEL_WIDTH-1:0] in_last,
    input  logic [PIXELS_PER_BEAT*CHANNELS*CHANNEL_WIDTH-1:0] in_cur,
    output logic                                              out_valid,
    input  logic                                              out_ready,
    output logic                                              out_sof,
    output logic                                              out_eol,
    output logic [PIXELS_PER_BEAT*CHANNELS*CHANNEL_WIDTH-1:0] out_data,
    output logic                                              err_sof_misalign
);
    localparam int LANES = PIXELS_PER_BEAT * CHANNELS;
    localparam int DW    = LANES * CHANNEL_WIDTH;
    localparam int WV    = WEIGHT_WIDTH + 1;
    localparam int PW    = CHANNEL_WIDTH + WEIGHT_WIDTH + 1;
    localparam int CNTW  = (BEATS_PER_LINE > 1) ? $clog2(BEATS_PER_LINE) : 1;

    localparam logic [WV-1:0]   W_FULL     = WV'(2 ** WEIGHT_WIDTH);
    localparam logic [WV-1:0]   W_HALF     = WV'(2 ** (WEIGHT_WIDTH - 1));
    localparam logic [PW-1:0]   ROUND_HALF = PW'(2 ** (WEIGHT_WIDTH - 1));
    localparam logic [CNTW-1:0] LAST_BEAT  = CNTW'(BEATS_PER_LINE - 1);

    typedef enum logic [1:0] {
        MODE_BLEND = 2'd0,
        MODE_LAST  = 2'd1,
        MODE_CUR   = 2'd2,
        MODE_AVG   = 2'd3
    } mode_e;

    function automatic logic [WV-1:0] sat_weight(input logic [WV-1:0] w);
        logic [WV-1:0] r;
        if (w > W_FULL) r = W_FULL;
        else            r = w;
        return r;
    endfunction

    function automatic logic [WV-1:0] eff_weight(input mode_e m, input logic [WV-1:0] w);
        logic [WV-1:0] r;
        case (m)
            MODE_BLEND: r = w;
            MODE_LAST:  r = WV'(0);
            MODE_CUR:   r = W_FULL;
            default:    r = W_HALF;
        endcase
        return r;
    endfunction

    logic [CNTW-1:0] count_q, count_d;
    logic [WV-1:0]   weight_q;
    mode_e           mode_q;
    logic            err_q;

    logic            s1_valid_q, s1_sof_q, s1_eol_q;
    logic [PW-1:0]   s1_pl_q [LANES];
    logic [PW-1:0]   s1_pc_q [LANES];
    logic [PW-1:0]   s1_pl_d [LANES];
    logic [PW-1:0]   s1_pc_d [LANES];

    logic            out_valid_q, out_sof_q, out_eol_q;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic [PW-1:0]   sum_s [LANES];

    logic            in_fire_s, s1_adv_s, s2_adv_s, eol_s;
    mode_e           sel_mode_s;
    logic [WV-1:0]   sel_weight_s, we_s, wl_s;
    logic [CNTW-1:0] beat_idx_s;

    // Handshake: a stage loads when empty or when its successor moves on.
    always_comb begin
        s2_adv_s  = !out_valid_q || out_ready;
        s1_adv_s  = !s1_valid_q || s2_adv_s;
        in_ready  = !rst && s1_adv_s;
        in_fire_s = in_valid && in_ready;
    end

    // An sof beat uses the incoming configuration directly and restarts the line.
    always_comb begin
        if (in_sof) begin
            sel_mode_s   = mode_e'(cfg_mode);
            sel_weight_s = sat_weight(cfg_weight);
            beat_idx_s   = CNTW'(0);
        end else begin
            sel_mode_s   = mode_q;
            sel_weight_s = weight_q;
            beat_idx_s   = count_q;
        end
        we_s  = eff_weight(sel_mode_s, sel_weight_s);
        wl_s  = W_FULL - we_s;
        eol_s = (beat_idx_s == LAST_BEAT);
        if (eol_s) count_d = CNTW'(0);
        else       count_d = beat_idx_s + CNTW'(1);
    end

    // Stage-1 datapath: both weighted products per channel at full width.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            s1_pl_d[i] = PW'(in_last[i*CHANNEL_WIDTH +: CHANNEL_WIDTH]) * PW'(wl_s);
            s1_pc_d[i] = PW'(in_cur[i*CHANNEL_WIDTH +: CHANNEL_WIDTH]) * PW'(we_s);
        end
    end

    // Stage-2 datapath: sum, half-up rounding, then drop the fractional bits.
    always_comb begin
        out_data_d = {DW{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            sum_s[i] = s1_pl_q[i] + s1_pc_q[i] + ROUND_HALF;
            out_data_d[i*CHANNEL_WIDTH +: CHANNEL_WIDTH] = sum_s[i][WEIGHT_WIDTH +: CHANNEL_WIDTH];
        end
    end

    // Line counter, latched frame configuration and sticky misalignment flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= CNTW'(0);
            weight_q <= W_HALF;
            mode_q   <= MODE_AVG;
            err_q    <= 1'b0;
        end else if (in_fire_s) begin
            count_q <= count_d;
            if (in_sof) begin
                weight_q <= sel_weight_s;
                mode_q   <= sel_mode_s;
                if (count_q != CNTW'(0)) err_q <= 1'b1;
            end
        end
    end

    // Stage-1 registers: products plus frame/line tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sof_q   <= 1'b0;
            s1_eol_q   <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                s1_pl_q[i] <= PW'(0);
                s1_pc_q[i] <= PW'(0);
            end
        end else if (s1_adv_s) begin
            s1_valid_q <= in_fire_s;
            if (in_fire_s) begin
                s1_sof_q <= in_sof;
                s1_eol_q <= eol_s;
                for (int i = 0; i < LANES; i++) begin
                    s1_pl_q[i] <= s1_pl_d[i];
                    s1_pc_q[i] <= s1_pc_d[i];
                end
            end
        end
    end

    // Stage-2 output registers; they hold while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            out_data_q  <= {DW{1'b0}};
        end else if (s2_adv_s) begin
            out_valid_q <= s1_valid_q;
            out_sof_q   <= s1_valid_q && s1_sof_q;
            out_eol_q   <= s1_valid_q && s1_eol_q;
            if (s1_valid_q) out_data_q <= out_data_d;
        end
    end

    assign out_valid        = out_valid_q;
    assign out_sof          = out_sof_q;
    assign out_eol          = out_eol_q;
    assign out_data         = out_data_q;
    assign err_sof_misalign = err_q;

endmodule

// File: tb/tb_frame_interpolator_weighted.sv
// Directed bench for frame_interpolator_weighted: reset, blend modes, config latching,
// backpressure, line counting, sof misalignment and mid-stream reset.
module tb_frame_interpolator_weighted;
    localparam int LANES = 12;
    localparam int DW    = 96;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    cfg_weight;
    logic [1:0]    cfg_mode;
    logic          in_valid, in_ready, in_sof;
    logic [DW-1:0] in_last, in_cur;
    logic          out_valid, out_ready, out_sof, out_eol;
    logic [DW-1:0] out_data;
    logic          err_sof_misalign;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    frame_interpolator_weighted #(
        .PIXELS_PER_BEAT(4), .CHANNELS(3), .CHANNEL_WIDTH(8),
        .WEIGHT_WIDTH(4), .BEATS_PER_LINE(320)
    ) dut (
        .clk(clk), .rst(rst), .cfg_weight(cfg_weight), .cfg_mode(cfg_mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
        .in_last(in_last), .in_cur(in_cur), .out_valid(out_valid),
        .out_ready(out_ready), .out_sof(out_sof), .out_eol(out_eol),
        .out_data(out_data), .err_sof_misalign(err_sof_misalign)
    );

    function automatic logic [DW-1:0] rep(input logic [7:0] v);
        return {LANES{v}};
    endfunction

    function automatic logic [7:0] blend(input logic [7:0] l, input logic [7:0] c, input int w);
        int p;
        p = int'(l) * (16 - w) + int'(c) * w + 8;
        return 8'(p / 16);
    endfunction

    function automatic logic [DW-1:0] bp_last(input int k);
        logic [DW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*8 +: 8] = 8'(k * 23 + i * 7);
        return r;
    endfunction

    function automatic logic [DW-1:0] bp_cur(input int k);
        logic [DW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*8 +: 8] = 8'(250 - k * 17 + i * 3);
        return r;
    endfunction

    function automatic logic [DW-1:0] bp_expect(input int k);
        logic [DW-1:0] r;
        for (int i = 0; i < LANES; i++)
            r[i*8 +: 8] = blend(8'(k * 23 + i * 7), 8'(250 - k * 17 + i * 3), 5);
        return r;
    endfunction

    task automatic idle();
        in_valid = 1'b0; in_sof = 1'b0;
        in_last = {DW{1'b0}}; in_cur = {DW{1'b0}};
    endtask

    task automatic apply_reset();
        idle();
        out_ready = 1'b1; cfg_weight = 5'd8; cfg_mode = 2'd0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        out_ready = 1'b1; cfg_weight = 5'd8; cfg_mode = 2'd0; rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (out_sof !== 1'b0 || out_eol !== 1'b0) begin n_bad++; $display("FAIL reset_tags: got sof=%b eol=%b expected 0/0", out_sof, out_eol); end
        n_cmp++; if (out_data !== {DW{1'b0}}) begin n_bad++; $display("FAIL reset_data: got %h expected 0", out_data); end
        n_cmp++; if (err_sof_misalign !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", err_sof_misalign); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready_low: got %b expected 0", in_ready); end
        rst = 1'b0; #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready_high: got %b expected 1", in_ready); end
        // Non-sof beat straight after reset uses the reset configuration (average).
        in_valid = 1'b1; in_last = rep(8'h10); in_cur = rep(8'h30);
        @(posedge clk); #1; idle();
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b1 || out_data !== rep(8'h20)) begin n_bad++; $display("FAIL reset_default_cfg: got v=%b %h expected v=1 %h", out_valid, out_data, rep(8'h20)); end
    endtask

    task automatic test_latch_blend();
        apply_reset();
        in_valid = 1'b1; in_sof = 1'b1; cfg_weight = 5'd4; cfg_mode = 2'd0;
        in_last = rep(8'h40); in_cur = rep(8'hC0);
        @(posedge clk); #1; idle();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL blend_latency1: got out_valid=%b expected 0", out_valid); end
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL blend_latency2: got out_valid=%b expected 1", out_valid); end
        n_cmp++; if (out_data !== rep(8'h60)) begin n_bad++; $display("FAIL blend_data: got %h expected %h", out_data, rep(8'h60)); end
        n_cmp++; if (out_sof !== 1'b1 || out_eol !== 1'b0) begin n_bad++; $display("FAIL blend_tags: got sof=%b eol=%b expected 1/0", out_sof, out_eol); end
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL blend_no_dup: got out_valid=%b expected 0", out_valid); end
    endtask

    task automatic test_modes();
        logic [4:0] tw [8] = '{5'd31, 5'd4, 5'd4, 5'd4, 5'd8, 5'd0, 5'd16, 5'd12};
        logic [1:0] tm [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
        logic [7:0] tl [8] = '{8'h12, 8'h12, 8'h12, 8'h01, 8'hFF, 8'h37, 8'h37, 8'h10};
        logic [7:0] tc [8] = '{8'hAB, 8'hAB, 8'hAB, 8'h02, 8'hFF, 8'hC8, 8'hC8, 8'h20};
        logic [7:0] te [8] = '{8'hAB, 8'h12, 8'hAB, 8'h02, 8'hFF, 8'h37, 8'hC8, 8'h1C};
        for (int i = 0; i < 8; i++) begin
            apply_reset();
            in_valid = 1'b1; in_sof = 1'b1; cfg_weight = tw[i]; cfg_mode = tm[i];
            in_last = rep(tl[i]); in_cur = rep(tc[i]);
            @(posedge clk); #1; idle();
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== rep(te[i])) begin
                n_bad++;
                $display("FAIL mode_case%0d: got v=%b %h expected v=1 %h", i, out_valid, out_data, rep(te[i]));
            end
        end
    endtask

    task automatic test_midframe_cfg();
        int got = 0;
        apply_reset();
        for (int c = 0; c < 12; c++) begin
            if (c < 9) begin
                in_valid = 1'b1; in_sof = (c == 0 || c == 8);
                cfg_weight = (c >= 5) ? 5'd12 : 5'd4; cfg_mode = 2'd0;
                in_last = rep(8'h40); in_cur = rep(8'hC0);
            end else begin
                idle();
            end
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin
                n_cmp++;
                if (out_data !== rep((got < 8) ? 8'h60 : 8'hA0) || out_sof !== (got == 0 || got == 8)) begin
                    n_bad++;
                    $display("FAIL midframe_beat%0d: got %h sof=%b expected %h sof=%b", got, out_data, out_sof,
                             rep((got < 8) ? 8'h60 : 8'hA0), (got == 0 || got == 8));
                end
                got++;
            end
        end
        n_cmp++; if (got != 9) begin n_bad++; $display("FAIL midframe_count: got %0d beats expected 9", got); end
    endtask

    task automatic test_backpressure();
        int sent = 0, recv = 0, inflight = 0;
        logic prev_stall = 1'b0, exp_rdy, fire_in, fire_out;
        logic [DW-1:0] prev_data = {DW{1'b0}};
        apply_reset();
        for (int c = 0; c < 300 && recv < 10; c++) begin
            if (prev_stall) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    n_bad++; $display("FAIL bp_hold: got v=%b %h expected v=1 %h", out_valid, out_data, prev_data);
                end
            end
            out_ready = ($urandom_range(0, 9) >= 3);
            if (sent < 10) begin
                in_valid = 1'b1; in_sof = (sent == 0); cfg_weight = 5'd5; cfg_mode = 2'd0;
                in_last = bp_last(sent); in_cur = bp_cur(sent);
            end else begin
                idle();
            end
            #1;
            exp_rdy = !(((inflight - int'(out_valid)) == 1) && out_valid && !out_ready);
            n_cmp++;
            if (in_ready !== exp_rdy) begin
                n_bad++; $display("FAIL bp_in_ready: got %b expected %b (inflight %0d)", in_ready, exp_rdy, inflight);
            end
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (fire_out) begin
                n_cmp++;
                if (out_data !== bp_expect(recv)) begin
                    n_bad++; $display("FAIL bp_data%0d: got %h expected %h", recv, out_data, bp_expect(recv));
                end
                recv++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            @(posedge clk); #1;
            if (fire_in) begin sent++; inflight++; end
            if (fire_out) inflight--;
        end
        n_cmp++; if (recv != 10) begin n_bad++; $display("FAIL bp_count: got %0d beats expected 10", recv); end
        out_ready = 1'b1; idle();
    endtask

    task automatic test_line_count();
        localparam int N = 967;
        int got = 0;
        logic exp_eol, exp_sof, exp_err;
        apply_reset();
        for (int i = 0; i < N + 3; i++) begin
            if (i < N) begin
                in_valid = 1'b1; in_sof = (i == 0 || i == 647); cfg_weight = 5'd8; cfg_mode = 2'd0;
                in_last = rep(8'(i)); in_cur = rep(8'(i + 1));
            end else begin
                idle();
            end
            @(posedge clk); #1;
            exp_err = (i >= 647);
            n_cmp++;
            if (err_sof_misalign !== exp_err) begin
                n_bad++; $display("FAIL line_err_cycle%0d: got %b expected %b", i, err_sof_misalign, exp_err);
            end
            if (out_valid === 1'b1) begin
                exp_eol = (got < 640) ? ((got % 320) == 319) : (got == 647 + 319);
                exp_sof = (got == 0 || got == 647);
                n_cmp++;
                if (out_eol !== exp_eol || out_sof !== exp_sof) begin
                    n_bad++; $display("FAIL line_tags_beat%0d: got eol=%b sof=%b expected eol=%b sof=%b",
                                      got, out_eol, out_sof, exp_eol, exp_sof);
                end
                got++;
            end
        end
        n_cmp++; if (got != N) begin n_bad++; $display("FAIL line_count: got %0d beats expected %0d", got, N); end
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_sof = 1'b1; cfg_weight = 5'd4; cfg_mode = 2'd0;
        in_last = rep(8'h11); in_cur = rep(8'h22);
        @(posedge clk); #1;
        in_last = rep(8'h33);
        @(posedge clk); #1; idle();
        n_cmp++; if (err_sof_misalign !== 1'b1 || out_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre: got err=%b v=%b expected 1/1", err_sof_misalign, out_valid); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (err_sof_misalign !== 1'b0) begin n_bad++; $display("FAIL rstmid_err: got %b expected 0", err_sof_misalign); end
        rst = 1'b0; out_ready = 1'b1; #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); end
        in_valid = 1'b1; in_sof = 1'b1; cfg_weight = 5'd4; cfg_mode = 2'd0;
        in_last = rep(8'h40); in_cur = rep(8'hC0);
        @(posedge clk); #1; idle();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_latency1: got out_valid=%b expected 0", out_valid); end
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b1 || out_data !== rep(8'h60) || out_sof !== 1'b1) begin
            n_bad++; $display("FAIL rstmid_beat: got v=%b sof=%b %h expected v=1 sof=1 %h", out_valid, out_sof, out_data, rep(8'h60));
        end
        n_cmp++; if (err_sof_misalign !== 1'b0) begin n_bad++; $display("FAIL rstmid_err_after: got %b expected 0", err_sof_misalign); end
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b1; cfg_weight = 5'd8; cfg_mode = 2'd0;
        idle();
        test_reset();
        test_latch_blend();
        test_modes();
        test_midframe_cfg();
        test_backpressure();
        test_line_count();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
